ltc2600_cmd_sequencer: RTL and testbench

// Command queue and sequencer placed directly upstream of the LTC2600 serial writer.

---
 rtl/ltc2600_cmd_sequencer.sv | 133 +++++++++++++
 tb/tb_ltc2600_cmd_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ltc2600_cmd_sequencer.sv
// Command FIFO and one-at-a-time issuer for the LTC2600 serial writer.
// A command is retired by a write_complete rising edge or by a WAIT timeout.
module ltc2600_cmd_sequencer #(
   parameter int DATA_WIDTH     = 16,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int GAP_CYCLES     = 2,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [3:0]                    in_command,
   input  logic [3:0]                    in_address,
   input  logic [DATA_WIDTH-1:0]         in_data,
   input  logic                          flush,
   input  logic                          err_clear,
   output logic                          send_new_cmd,
   output logic [3:0]                    command,
   output logic [3:0]                    address,
   output logic [DATA_WIDTH-1:0]         data,
   input  logic                          write_complete,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fill_level,
   output logic                          timeout_err,
   output logic [CNT_WIDTH-1:0]          cmds_done
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = AW + 1;
   localparam int EW = DATA_WIDTH + 8;
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0] G_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [FW-1:0] FULL   = FW'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_GAP   = 2'd3;

   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [FW-1:0] count;
   logic          ready_q, push, pop, empty, full;
   logic [1:0]    state;
   logic [TW-1:0] timer;
   logic [GW-1:0] gap_cnt;
   logic          wc_q, wc_rise, t_expire;

   assign empty      = (count == '0);
   assign full       = (count == FULL);
   // ready_q keeps in_ready low throughout reset and rises one edge after release
   assign in_ready   = ready_q && !full && !flush;
   assign push       = in_valid && in_ready;
   assign pop        = (state == S_IDLE) && !empty;
   assign fill_level = count;
   assign busy       = (state != S_IDLE) || !empty;
   assign wc_rise    = write_complete && !wc_q;
   assign t_expire   = (timer == T_LAST);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_command, in_address, in_data};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b1;
         if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= S_IDLE;
         timer        <= '0;
         gap_cnt      <= '0;
         wc_q         <= 1'b0;
         send_new_cmd <= 1'b0;
         command      <= '0;
         address      <= '0;
         data         <= '0;
         timeout_err  <= 1'b0;
         cmds_done    <= '0;
      end else begin
         wc_q         <= write_complete;
         // pulse lands one cycle after the outputs are loaded
         send_new_cmd <= (state == S_ISSUE);
         if (err_clear) timeout_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!empty) begin
                  {command, address, data} <= mem[rd_ptr];
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               timer <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               timer <= timer + 1'b1;
               if (wc_rise || t_expire) begin
                  // a completion coinciding with expiry is still a completion
                  if (wc_rise) cmds_done   <= cmds_done + 1'b1;
                  else         timeout_err <= 1'b1;
                  gap_cnt <= '0;
                  state   <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
               end
            end
            S_GAP: begin
               gap_cnt <= gap_cnt + 1'b1;
               if (gap_cnt == G_LAST) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ltc2600_cmd_sequencer.sv
// Directed bench for ltc2600_cmd_sequencer with a simple writer model.
// CNT_WIDTH is reduced to 4 so the completion counter wrap is reachable.
module tb_ltc2600_cmd_sequencer;
   localparam int DW = 16;
   localparam int CW = 4;

   logic          clk = 1'b0, rstn = 1'b0;
   logic          in_valid = 1'b0, flush = 1'b0, err_clear = 1'b0;
   logic          write_complete = 1'b0;
   logic [3:0]    in_command = '0, in_address = '0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready, send_new_cmd, busy, timeout_err;
   logic [3:0]    command, address;
   logic [DW-1:0] data;
   logic [3:0]    fill_level;
   logic [CW-1:0] cmds_done;

   int total = 0, bad = 0;
   int wr_mode = 0;   // 0 pulse, 1 hold high, 2 never answer
   int wr_delay = 40;
   logic [23:0] iss_q[$];

   ltc2600_cmd_sequencer #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(256),
      .GAP_CYCLES(2), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .in_command(in_command), .in_address(in_address), .in_data(in_data),
      .flush(flush), .err_clear(err_clear), .send_new_cmd(send_new_cmd),
      .command(command), .address(address), .data(data),
      .write_complete(write_complete), .busy(busy), .fill_level(fill_level),
      .timeout_err(timeout_err), .cmds_done(cmds_done)
   );

   always #5 clk = ~clk;

   // writer model: logs each issued frame, answers wr_delay cycles later
   initial begin
      forever begin
         @(negedge clk);
         if (send_new_cmd === 1'b1) begin
            iss_q.push_back({command, address, data});
            write_complete = 1'b0;
            if (wr_mode != 2) begin
               repeat (wr_delay) @(negedge clk);
               write_complete = 1'b1;
               if (wr_mode == 0) begin
                  @(negedge clk);
                  write_complete = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic [3:0] c, input logic [3:0] a, input logic [DW-1:0] d);
      int t = 0;
      in_valid = 1'b1; in_command = c; in_address = a; in_data = d;
      while (in_ready !== 1'b1 && t < 2000) begin @(negedge clk); t++; end
      if (t >= 2000) begin
         total++; bad++;
         $display("FAIL push_accept: in_ready stuck at %b", in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_send(input string tag);
      int t = 0;
      while (send_new_cmd !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
      if (t >= 1000) begin
         total++; bad++;
         $display("FAIL %s: send_new_cmd never seen", tag);
      end
   endtask

   task automatic wait_done(input logic [CW-1:0] target, input string tag);
      int t = 0;
      while (cmds_done !== target && t < 3000) begin @(negedge clk); t++; end
      if (t >= 3000) begin
         total++; bad++;
         $display("FAIL %s: cmds_done=%0d expected %0d", tag, cmds_done, target);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", in_ready); end
      total++; if ({send_new_cmd, busy, timeout_err} !== 3'b000) begin bad++;
         $display("FAIL rst_flags: got %b want 000", {send_new_cmd, busy, timeout_err}); end
      total++; if ({command, address, data, fill_level, cmds_done} !== 32'h0) begin bad++;
         $display("FAIL rst_values: got %h want 0", {command, address, data, fill_level, cmds_done}); end
      rstn = 1'b1;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_ready: got %b want 1", in_ready); end
      total++; if (busy !== 1'b0 || fill_level !== 4'd0) begin bad++;
         $display("FAIL rel_idle: busy=%b fill=%0d want 0 0", busy, fill_level); end
   endtask

   task automatic test_single();
      wr_mode = 0; wr_delay = 40; iss_q.delete();
      in_valid = 1'b1; in_command = 4'd3; in_address = 4'd2; in_data = 16'hABCD;
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (fill_level !== 4'd1 || command !== 4'd0) begin bad++;
         $display("FAIL single_e0: fill=%0d cmd=%0d want 1 0", fill_level, command); end
      @(negedge clk);
      total++; if ({command, address, data} !== {4'd3, 4'd2, 16'hABCD} || send_new_cmd !== 1'b0) begin bad++;
         $display("FAIL single_e1: out=%h send=%b want 32abcd 0", {command, address, data}, send_new_cmd); end
      @(negedge clk);
      total++; if (send_new_cmd !== 1'b1) begin bad++; $display("FAIL single_e2: send=%b want 1", send_new_cmd); end
      @(negedge clk);
      total++; if (send_new_cmd !== 1'b0) begin bad++; $display("FAIL single_e3: send=%b want 0", send_new_cmd); end
      repeat (39) @(negedge clk);
      total++; if (cmds_done !== 4'd0) begin bad++; $display("FAIL single_early: cmds_done=%0d want 0", cmds_done); end
      @(negedge clk);
      total++; if (cmds_done !== 4'd1 || busy !== 1'b1) begin bad++;
         $display("FAIL single_done: cmds_done=%0d busy=%b want 1 1", cmds_done, busy); end
      @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_gap: busy=%b want 1", busy); end
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: busy=%b want 0", busy); end
      total++; if (iss_q.size() != 1) begin bad++; $display("FAIL single_issues: got %0d want 1", iss_q.size()); end
   endtask

   task automatic test_burst();
      logic [23:0] exp;
      wr_mode = 0; wr_delay = 40; iss_q.delete();
      for (int i = 0; i < 9; i++) push(4'(i), 4'(15 - i), 16'h1000 + 16'(i));
      total++; if (fill_level !== 4'd8 || in_ready !== 1'b0) begin bad++;
         $display("FAIL burst_full: fill=%0d ready=%b want 8 0", fill_level, in_ready); end
      wait_done(4'd10, "burst_wait");
      total++; if (cmds_done !== 4'd10) begin bad++; $display("FAIL burst_count: got %0d want 10", cmds_done); end
      total++; if (iss_q.size() != 9) begin bad++; $display("FAIL burst_issues: got %0d want 9", iss_q.size()); end
      for (int i = 0; i < 9 && iss_q.size() > 0; i++) begin
         exp = {4'(i), 4'(15 - i), 16'h1000 + 16'(i)};
         total++; if (iss_q[0] !== exp) begin bad++;
            $display("FAIL burst_order%0d: got %h want %h", i, iss_q[0], exp); end
         void'(iss_q.pop_front());
      end
   endtask

   task automatic test_timeout();
      logic [CW-1:0] base;
      wr_mode = 2; iss_q.delete(); base = cmds_done;
      push(4'd1, 4'd1, 16'h0111);
      push(4'd2, 4'd2, 16'h0222);
      push(4'd3, 4'd3, 16'h0333);
      wait_send("to_send_a");
      repeat (255) @(negedge clk);
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_early: err=%b want 0", timeout_err); end
      @(negedge clk);
      total++; if (timeout_err !== 1'b1 || cmds_done !== base) begin bad++;
         $display("FAIL to_set: err=%b done=%0d want 1 %0d", timeout_err, cmds_done, base); end
      wait_send("to_send_b");
      repeat (10) @(negedge clk);
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_clear: err=%b want 0", timeout_err); end
      repeat (244) @(negedge clk);
      total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_b_early: err=%b want 0", timeout_err); end
      err_clear = 1'b1; wr_mode = 0; wr_delay = 5;
      @(negedge clk);
      err_clear = 1'b0;
      total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_clr_vs_set: err=%b want 1", timeout_err); end
      wait_done(base + 4'd1, "to_c_wait");
      total++; if (cmds_done !== base + 4'd1) begin bad++;
         $display("FAIL to_count: got %0d want %0d", cmds_done, base + 4'd1); end
      total++; if (iss_q.size() != 3 || iss_q[2] !== {4'd3, 4'd3, 16'h0333} || iss_q[1] !== {4'd2, 4'd2, 16'h0222}) begin bad++;
         $display("FAIL to_issues: size=%0d want 3 in order", iss_q.size()); end
      err_clear = 1'b1;
      @(negedge clk);
      err_clear = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_flush();
      logic [CW-1:0] base;
      wr_mode = 0; wr_delay = 40; iss_q.delete(); base = cmds_done;
      for (int i = 0; i < 6; i++) push(4'd5, 4'(i), 16'h5000 + 16'(i));
      total++; if (fill_level !== 4'd5) begin bad++; $display("FAIL fl_pre: fill=%0d want 5", fill_level); end
      flush = 1'b1; in_valid = 1'b1; in_command = 4'hF; in_address = 4'hF; in_data = 16'hFFFF;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fl_ready: got %b want 0", in_ready); end
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      total++; if (fill_level !== 4'd0) begin bad++; $display("FAIL fl_empty: fill=%0d want 0", fill_level); end
      repeat (80) @(negedge clk);
      total++; if (cmds_done !== base + 4'd1 || busy !== 1'b0) begin bad++;
         $display("FAIL fl_done: done=%0d busy=%b want %0d 0", cmds_done, busy, base + 4'd1); end
      total++; if (iss_q.size() != 1 || iss_q[0] !== {4'd5, 4'd0, 16'h5000}) begin bad++;
         $display("FAIL fl_issues: size=%0d want 1 (5 0 5000)", iss_q.size()); end
   endtask

   task automatic test_level();
      logic [CW-1:0] base;
      wr_mode = 1; wr_delay = 6; iss_q.delete(); base = cmds_done;
      for (int i = 0; i < 3; i++) push(4'd7, 4'd9, 16'h7700 + 16'(i));
      wait_done(base + 4'd3, "lvl_wait");
      repeat (40) @(negedge clk);
      total++; if (cmds_done !== base + 4'd3) begin bad++;
         $display("FAIL lvl_count: got %0d want %0d", cmds_done, base + 4'd3); end
      total++; if (iss_q.size() != 3 || iss_q[2] !== {4'd7, 4'd9, 16'h7702}) begin bad++;
         $display("FAIL lvl_issues: size=%0d want 3", iss_q.size()); end
   endtask

   task automatic test_wrap();
      wr_mode = 0; wr_delay = 3;
      total++; if (cmds_done !== 4'hF) begin bad++; $display("FAIL wrap_pre: got %0d want 15", cmds_done); end
      push(4'd1, 4'd0, 16'h0001);
      wait_done(4'd0, "wrap_wait");
      total++; if (cmds_done !== 4'd0) begin bad++; $display("FAIL wrap: got %0d want 0", cmds_done); end
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      wr_mode = 0; wr_delay = 40;
      push(4'd8, 4'd8, 16'h8888);
      push(4'd9, 4'd9, 16'h9999);
      wait_send("rm_send");
      repeat (5) @(negedge clk);
      rstn = 1'b0;
      #1;
      total++; if ({in_ready, send_new_cmd, busy, timeout_err} !== 4'b0000) begin bad++;
         $display("FAIL rm_flags: got %b want 0000", {in_ready, send_new_cmd, busy, timeout_err}); end
      total++; if ({command, address, data, fill_level, cmds_done} !== 32'h0) begin bad++;
         $display("FAIL rm_values: got %h want 0", {command, address, data, fill_level, cmds_done}); end
      repeat (2) @(negedge clk);
      rstn = 1'b1; iss_q.delete();
      @(negedge clk);
      total++; if (in_ready !== 1'b1 || fill_level !== 4'd0 || busy !== 1'b0) begin bad++;
         $display("FAIL rm_release: ready=%b fill=%0d busy=%b want 1 0 0", in_ready, fill_level, busy); end
      repeat (60) @(negedge clk);
      total++; if (iss_q.size() != 0 || cmds_done !== 4'd0) begin bad++;
         $display("FAIL rm_quiet: issues=%0d done=%0d want 0 0", iss_q.size(), cmds_done); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_timeout();
      test_flush();
      test_level();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
